// File: rtl/rtg_pkg.sv
// Shared types and constants for the raster line fetcher: FSM states,
// pixel-format decode and default burst/FIFO sizing.
package rtg_pkg;

    localparam int BURST_DEFAULT      = 16;
    localparam int FIFO_DEPTH_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LINE = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_NEXT      = 3'd4
    } state_e;

    localparam logic [2:0] BPP_FMT0  = 3'd1;
    localparam logic [2:0] BPP_FMT1  = 3'd2;
    localparam logic [2:0] BPP_FMT23 = 3'd4;

    function automatic logic [2:0] fmt_bpp(input logic [1:0] fmt);
        case (fmt)
            2'd0:    return BPP_FMT0;
            2'd1:    return BPP_FMT1;
            default: return BPP_FMT23;
        endcase
    endfunction

    // ceil(hsize*bpp/2); the worst case (4095*4+1)>>1 = 8190 fits in 13 bits
    function automatic logic [12:0] line_words(input logic [11:0] hsize, input logic [1:0] fmt);
        return 13'((14'(hsize) * 14'(fmt_bpp(fmt)) + 14'd1) >> 1);
    endfunction

endpackage

// File: rtl/rtg_fetch_if.sv
// Burst read bus between the line fetcher (master) and the memory port (slave).
interface rtg_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [6:0]  mem_len;
    logic        mem_ack;
    logic        mem_valid;
    logic [15:0] mem_data;

    modport master (
        output mem_req, mem_addr, mem_len,
        input  mem_ack, mem_valid, mem_data
    );

    modport slave (
        input  mem_req, mem_addr, mem_len,
        output mem_ack, mem_valid, mem_data
    );
endinterface

// File: rtl/rtg_fetch_fifo.sv
// First-word-fall-through line FIFO; head word is driven combinationally and
// forced to zero while empty so the reset/flush value is deterministic.
module rtg_fetch_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The fetcher only requests bursts that fit, so this must never fire.
    assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/rtg_fetch.sv
// Raster line fetcher: turns vs/hs timing into memory bursts and buffers the
// line in a FWFT FIFO. Optional underrun tracking: define RTG_FETCH_UNDERRUN_EN.
module rtg_fetch
    import rtg_pkg::*;
#(
    parameter int BURST      = BURST_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic [31:0] base,
    input  logic [13:0] stride,
    input  logic [11:0] hsize,
    input  logic [11:0] vsize,
    input  logic [4:0]  format,
    input  logic        vs,
    input  logic        hs,
    rtg_fetch_if.master mem,
    input  logic        fifo_rd,
    output logic [15:0] fifo_dout,
    output logic        fifo_empty,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e      state_q, state_d;
    logic [11:0] line_q, line_d;
    logic [31:0] line_addr_q, line_addr_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [12:0] words_left_q, words_left_d;
    logic [6:0]  burst_left_q, burst_left_d;
    logic        pend_q, pend_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [6:0]  mem_len_q, mem_len_d;

    logic          restart;
    logic          fifo_push;
    logic          fifo_flush;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] free_words;
    logic [CW-1:0] in_flight;
    logic [6:0]    next_len;
    logic          space_ok;
    logic [12:0]   wpl;
    logic          stop_req;

    assign wpl        = line_words(hsize, format[1:0]);
    assign free_words = CW'(FIFO_DEPTH) - fifo_count;
    assign in_flight  = (state_q == ST_DATA) ? CW'(burst_left_q) : '0;
    assign next_len   = (words_left_q > 13'(BURST)) ? 7'(BURST) : words_left_q[6:0];
    assign space_ok   = ({1'b0, free_words} >= ({1'b0, in_flight} + {1'b0, CW'(next_len)}));
    assign stop_req   = vs || !ena;
    assign fifo_flush = restart && ena;
    assign busy       = (state_q == ST_REQ) || (state_q == ST_DATA) || (state_q == ST_NEXT);

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_len  = mem_len_q;

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        line_addr_d  = line_addr_q;
        cur_addr_d   = cur_addr_q;
        words_left_d = words_left_q;
        burst_left_d = burst_left_q;
        pend_d       = pend_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_len_d    = mem_len_q;
        restart      = 1'b0;
        fifo_push    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (vs && ena) restart = 1'b1;
            end
            ST_WAIT_LINE: begin
                if (stop_req) begin
                    restart = 1'b1;
                end else if (hs && (line_q < vsize)) begin
                    words_left_d = wpl;
                    cur_addr_d   = line_addr_q;
                    state_d      = (wpl == '0) ? ST_NEXT : ST_REQ;
                end
            end
            ST_REQ: begin
                // An accepted request always runs to completion, even with a restart pending.
                if (mem_req_q && mem.mem_ack) begin
                    mem_req_d    = 1'b0;
                    cur_addr_d   = cur_addr_q + {24'b0, mem_len_q, 1'b0};
                    words_left_d = words_left_q - {6'b0, mem_len_q};
                    burst_left_d = mem_len_q;
                    pend_d       = stop_req;
                    state_d      = ST_DATA;
                end else if (stop_req) begin
                    mem_req_d = 1'b0;
                    restart   = 1'b1;
                end else if (!mem_req_q && space_ok) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = cur_addr_q;
                    mem_len_d  = next_len;
                end
            end
            ST_DATA: begin
                if (stop_req) pend_d = 1'b1;
                if (mem.mem_valid) begin
                    fifo_push    = 1'b1;
                    burst_left_d = burst_left_q - 7'd1;
                    if (burst_left_q == 7'd1) begin
                        if (pend_q || stop_req) restart = 1'b1;
                        else state_d = (words_left_q != '0) ? ST_REQ : ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (stop_req) begin
                    restart = 1'b1;
                end else begin
                    line_addr_d = line_addr_q + {18'b0, stride[13:1], 1'b0};
                    line_d      = line_q + 12'd1;
                    state_d     = ST_WAIT_LINE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (restart) begin
            pend_d = 1'b0;
            if (ena) begin
                state_d     = ST_WAIT_LINE;
                line_d      = '0;
                line_addr_d = {base[31:1], 1'b0};
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            line_q       <= '0;
            line_addr_q  <= '0;
            cur_addr_q   <= '0;
            words_left_q <= '0;
            burst_left_q <= '0;
            pend_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            line_addr_q  <= line_addr_d;
            cur_addr_q   <= cur_addr_d;
            words_left_q <= words_left_d;
            burst_left_q <= burst_left_d;
            pend_q       <= pend_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_len_q    <= mem_len_d;
        end
    end

    rtg_fetch_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(16)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (mem.mem_data),
        .pop   (fifo_rd),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

`ifdef RTG_FETCH_UNDERRUN_EN
    logic        underrun_q;
    logic [15:0] underrun_cnt_q;
    logic        under_evt;

    assign under_evt = fifo_rd && fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            if (under_evt)  underrun_q <= 1'b1;
            else if (vs)    underrun_q <= 1'b0;
            if (under_evt && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;
`else
    assign underrun     = 1'b0;
    assign underrun_cnt = '0;
`endif

    logic unused_ok;
    assign unused_ok = ^{format[4:2], fifo_full};

endmodule

// File: tb/tb_rtg_fetch.sv
// Scoreboard bench for rtg_fetch: expected bursts and FIFO words are queued by
// the directed sequence and popped by the memory responder / display consumer.
`timescale 1ns/1ps
module tb_rtg_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        ena = 1'b1;
    logic [31:0] base;
    logic [13:0] stride;
    logic [11:0] hsize;
    logic [11:0] vsize;
    logic [4:0]  format;
    logic        vs = 1'b0;
    logic        hs = 1'b0;
    logic        auto_rd = 1'b0;
    logic        man_rd = 1'b0;
    logic        fifo_rd;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic        busy;
    logic        underrun;
    logic [15:0] underrun_cnt;

    assign fifo_rd = auto_rd | man_rd;

    rtg_fetch_if mif();

    rtg_fetch #(.BURST(16), .FIFO_DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .ena          (ena),
        .base         (base),
        .stride       (stride),
        .hsize        (hsize),
        .vsize        (vsize),
        .format       (format),
        .vs           (vs),
        .hs           (hs),
        .mem          (mif),
        .fifo_rd      (fifo_rd),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

`ifdef RTG_FETCH_UNDERRUN_EN
    localparam logic [31:0] EXP_UFLAG = 32'd1;
    localparam logic [31:0] EXP_UCNT  = 32'd3;
`else
    localparam logic [31:0] EXP_UFLAG = 32'd0;
    localparam logic [31:0] EXP_UCNT  = 32'd0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [6:0]  len;
    } burst_t;

    burst_t      exp_burst[$];
    logic [15:0] exp_data[$];
    int          tests = 0;
    int          fails = 0;
    int          bursts_seen = 0;
    int          words_sent = 0;
    logic        ack_en = 1'b1;
    logic        drain_en = 1'b1;
    logic        in_data = 1'b0;
    logic [15:0] data_seq = 16'h0100;
    logic [15:0] next_seq = 16'h0100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic exp_b(input logic [31:0] a, input logic [6:0] l);
        burst_t e;
        e.addr = a;
        e.len  = l;
        exp_burst.push_back(e);
    endtask

    task automatic expect_words(input int n);
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(next_seq);
            next_seq = next_seq + 16'd1;
        end
    endtask

    task automatic skip_words(input int n);
        next_seq = next_seq + 16'(n);
    endtask

    task automatic pulse_vs();
        @(negedge clk); vs = 1'b1;
        @(negedge clk); vs = 1'b0;
    endtask

    task automatic pulse_hs();
        @(negedge clk); hs = 1'b1;
        @(negedge clk); hs = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy === 1'b1 || in_data || mif.mem_req === 1'b1 ||
                (drain_en && fifo_empty === 1'b0)) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) timeout_fail(name);
    endtask

    task automatic wait_in_data(input logic want, input string name);
        int n;
        n = 0;
        while (in_data !== want && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout_fail(name);
    endtask

    // Memory responder: acks a request, checks it against the scoreboard, then streams words.
    initial begin
        int     len;
        burst_t e;
        mif.mem_ack   = 1'b0;
        mif.mem_valid = 1'b0;
        mif.mem_data  = '0;
        forever begin
            @(negedge clk);
            if (mif.mem_req === 1'b1 && ack_en) begin
                bursts_seen++;
                if (exp_burst.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL burst: unexpected request addr 0x%0h len %0d", mif.mem_addr, mif.mem_len);
                end else begin
                    e = exp_burst.pop_front();
                    check("burst_addr", mif.mem_addr, e.addr);
                    check("burst_len", 32'(mif.mem_len), 32'(e.len));
                end
                len = int'(mif.mem_len);
                mif.mem_ack = 1'b1;
                @(negedge clk);
                mif.mem_ack = 1'b0;
                for (int k = 0; k < len; k++) begin
                    mif.mem_valid = 1'b1;
                    mif.mem_data  = data_seq;
                    data_seq      = data_seq + 16'd1;
                    words_sent++;
                    in_data       = 1'b1;
                    @(negedge clk);
                end
                mif.mem_valid = 1'b0;
                in_data       = 1'b0;
            end
        end
    end

    // Display consumer: pops and checks every head word while draining is enabled.
    initial begin
        logic [15:0] w;
        forever begin
            @(negedge clk);
            auto_rd = 1'b0;
            if (drain_en && fifo_empty === 1'b0) begin
                if (exp_data.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL fifo_data: unexpected word 0x%0h", fifo_dout);
                end else begin
                    w = exp_data.pop_front();
                    check("fifo_data", 32'(fifo_dout), 32'(w));
                end
                auto_rd = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int b0;
        int w0;
        reset  = 1'b1;
        base   = 32'h0000_1000;
        stride = 14'h0200;
        hsize  = 12'd320;
        vsize  = 12'd4;
        format = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mif.mem_req), 32'd0);
        check("rst_mem_addr", mif.mem_addr, 32'd0);
        check("rst_mem_len", 32'(mif.mem_len), 32'd0);
        check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        check("rst_fifo_dout", 32'(fifo_dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
        reset = 1'b0;

        // 320 px at 1 B/px: ten 16-word bursts, hs mid-line is dropped
        for (int i = 0; i < 10; i++) exp_b(32'h0000_1000 + 32'(32 * i), 7'd16);
        expect_words(160);
        b0 = bursts_seen;
        w0 = words_sent;
        pulse_vs();
        pulse_hs();
        repeat (40) @(negedge clk);
        check("busy_mid_line", 32'(busy), 32'd1);
        pulse_hs();
        wait_idle("line0");
        check("line0_bursts", 32'(bursts_seen - b0), 32'd10);
        check("line0_words", 32'(words_sent - w0), 32'd160);
        check("line0_busy_done", 32'(busy), 32'd0);

        // 7 px at 2 B/px on line 1: one short burst
        hsize  = 12'd7;
        format = 5'd1;
        exp_b(32'h0000_1200, 7'd7);
        expect_words(7);
        b0 = bursts_seen;
        pulse_hs();
        wait_idle("line1");
        check("line1_bursts", 32'(bursts_seen - b0), 32'd1);

        // Line address wraps modulo 2^32; fourth hs beyond vsize is ignored
        base   = 32'hFFFF_FF00;
        stride = 14'h0200;
        hsize  = 12'd4;
        format = 5'd0;
        vsize  = 12'd3;
        exp_b(32'hFFFF_FF00, 7'd2);
        exp_b(32'h0000_0100, 7'd2);
        exp_b(32'h0000_0300, 7'd2);
        expect_words(6);
        b0 = bursts_seen;
        pulse_vs();
        for (int i = 0; i < 3; i++) begin
            pulse_hs();
            wait_idle("wrap_line");
        end
        pulse_hs();
        check("hs_past_vsize_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("wrap_bursts", 32'(bursts_seen - b0), 32'd3);

        // Request held without ack, then vs in DATA restarts the frame
        base     = 32'h0000_2000;
        hsize    = 12'd32;
        vsize    = 12'd4;
        ack_en   = 1'b0;
        drain_en = 1'b0;
        exp_b(32'h0000_2000, 7'd16);
        pulse_vs();
        pulse_hs();
        begin
            int n;
            n = 0;
            while (mif.mem_req !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) timeout_fail("req_wait");
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_addr", mif.mem_addr, 32'h0000_2000);
            check("hold_len", 32'(mif.mem_len), 32'd16);
        end
        ack_en = 1'b1;
        wait_in_data(1'b1, "data_start");
        repeat (3) @(negedge clk);
        pulse_vs();
        wait_in_data(1'b0, "data_end");
        skip_words(16);
        repeat (2) @(negedge clk);
        check("vs_data_busy", 32'(busy), 32'd0);
        check("vs_data_flushed", 32'(fifo_empty), 32'd1);
        drain_en = 1'b1;
        exp_b(32'h0000_2000, 7'd16);
        expect_words(16);
        pulse_hs();
        wait_idle("restart_line");

        // Reads from an empty FIFO
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); man_rd = 1'b1;
            @(negedge clk); man_rd = 1'b0;
        end
        @(negedge clk);
        check("underrun_flag", 32'(underrun), EXP_UFLAG);
        check("underrun_cnt", 32'(underrun_cnt), EXP_UCNT);
        pulse_vs();
        check("underrun_cleared", 32'(underrun), 32'd0);
        check("underrun_cnt_kept", 32'(underrun_cnt), EXP_UCNT);

        // Reset in the middle of a burst; trailing words must be discarded
        base = 32'h0000_3000;
        exp_b(32'h0000_3000, 7'd16);
        pulse_vs();
        pulse_hs();
        wait_in_data(1'b1, "rst_data_start");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_mem_req", 32'(mif.mem_req), 32'd0);
        check("midrst_mem_addr", mif.mem_addr, 32'd0);
        check("midrst_mem_len", 32'(mif.mem_len), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_fifo_empty", 32'(fifo_empty), 32'd1);
        check("midrst_fifo_dout", 32'(fifo_dout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_in_data(1'b0, "rst_data_end");
        skip_words(16);
        repeat (2) @(negedge clk);
        check("postrst_fifo_empty", 32'(fifo_empty), 32'd1);
        check("postrst_busy", 32'(busy), 32'd0);

        drain_en = 1'b1;
        repeat (5) @(negedge clk);
        check("burst_queue_drained", 32'(exp_burst.size()), 32'd0);
        check("data_queue_drained", 32'(exp_data.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtg_fetch.md
RTG_FETCH -- requirements
Module: rtg_fetch

Interface
REQ-001 The block SHALL have parameter BURST, default 16, the maximum number of 16-bit words per memory burst (power of 2, 4..64).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 64, the line FIFO depth in 16-bit words (power of 2, at least 2*BURST).
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port ena, input, 1 bit: scanout enable.
REQ-006 Port base, input, 32 bits: framebuffer byte address; bit 0 is ignored.
REQ-007 Port stride, input, 14 bits: line pitch in bytes; bit 0 is ignored.
REQ-008 Port hsize, input, 12 bits: pixels per line.
REQ-009 Port vsize, input, 12 bits: lines per frame.
REQ-010 Port format, input, 5 bits: pixel format; only bits [1:0] are used.
REQ-011 Port vs, input, 1 bit: frame-start pulse, one clock wide.
REQ-012 Port hs, input, 1 bit: line-fetch request pulse, one clock wide.
REQ-013 Port mem_req, output, 1 bit: burst request.
REQ-014 Port mem_addr, output, 32 bits: burst start byte address; bit 0 is always 0.
REQ-015 Port mem_len, output, 7 bits: burst length in words, range 1..BURST.
REQ-016 Port mem_ack, input, 1 bit: request accepted.
REQ-017 Port mem_valid, input, 1 bit: a data word is present on mem_data.
REQ-018 Port mem_data, input, 16 bits: read data.
REQ-019 Port fifo_rd, input, 1 bit: display pops one word.
REQ-020 Port fifo_dout, output, 16 bits: FIFO head word.
REQ-021 Port fifo_empty, output, 1 bit: FIFO holds no words.
REQ-022 Port busy, output, 1 bit: a line fetch is in progress.
REQ-023 Port underrun, output, 1 bit: sticky underrun flag.
REQ-024 Port underrun_cnt, output, 16 bits: count of underrun events.

Function
REQ-025 Bytes per pixel SHALL be decoded from format[1:0]: 0 gives 1 byte, 1 gives 2 bytes, 2 and 3 give 4 bytes; words per line = ceil(hsize*bpp/2), held in 13 bits.
REQ-026 The FSM SHALL have the states IDLE, WAIT_LINE, REQ, DATA and NEXT.
REQ-027 In IDLE, a vs pulse with ena=1 SHALL set line to 0, set line_addr to base, flush the FIFO and move to WAIT_LINE.
REQ-028 In WAIT_LINE, hs with line<vsize SHALL load words_left and cur_addr=line_addr and move to REQ; hs with line>=vsize SHALL be ignored.
REQ-029 REQ SHALL assert mem_req, with mem_len=min(BURST, words_left), only when FIFO free space minus in-flight words is at least mem_len.
REQ-030 mem_req, mem_addr and mem_len SHALL stay stable until mem_ack; on mem_ack the FSM SHALL move to DATA, add 2*mem_len to cur_addr and subtract mem_len from words_left.
REQ-031 In DATA, each mem_valid SHALL push mem_data into the FIFO; after mem_len words the FSM SHALL move to REQ if words_left>0, else to NEXT.
REQ-032 NEXT SHALL, in one cycle, add stride to line_addr (32-bit add, wrapping modulo 2^32), increment line and return to WAIT_LINE.
REQ-033 busy SHALL be 1 in the REQ, DATA and NEXT states.
REQ-034 An hs pulse while busy=1 SHALL be dropped, with no other effect.
REQ-035 A vs pulse in WAIT_LINE, REQ or NEXT SHALL restart the frame as in REQ-027 on the next cycle, with no burst issued from REQ.
REQ-036 A vs pulse in DATA SHALL be latched as pending and applied when the burst completes; the remaining burst data is still accepted.
REQ-037 ena=0 SHALL return the FSM to IDLE under the same rules as vs.
REQ-038 The FIFO SHALL be first-word-fall-through with fifo_dout valid whenever fifo_empty=0; a simultaneous push and pop SHALL leave the FIFO count unchanged.
REQ-039 fifo_rd while fifo_empty=1 SHALL not change the FIFO and is an underrun event.
REQ-040 A push when the FIFO is full is unreachable by REQ-029 and SHALL be flagged by an assertion.

Reset
REQ-041 Reset SHALL immediately force: state IDLE; mem_req 0; mem_addr 0; mem_len 0; FIFO flushed; fifo_empty 1; fifo_dout 0; busy 0; underrun 0; underrun_cnt 0; line 0; the pending flag cleared.
REQ-042 Words arriving after reset SHALL be discarded.

Configuration
REQ-043 With RTG_FETCH_UNDERRUN_EN defined, an underrun event SHALL set underrun (cleared only by reset or by vs) and SHALL increment underrun_cnt, saturating at 0xFFFF.
REQ-044 Without RTG_FETCH_UNDERRUN_EN, underrun and underrun_cnt SHALL be constant 0 and the underrun logic SHALL not be synthesized.

Structure
REQ-045 Package rtg_pkg SHALL hold the FSM state enum, the format-to-bpp decode constants and the BURST and FIFO_DEPTH defaults.
REQ-046 The FIFO SHALL be the sub-module rtg_fetch_fifo (synchronous, FWFT, parameterized depth).

Verification
REQ-047 hsize=320, format=0, BURST=16: vs then hs -> 10 bursts of 16 words at base, base+32, ..., base+288; busy falls after the 160th word.
REQ-048 hsize=7, format=1 -> exactly one burst with mem_len=7.
REQ-049 base=0xFFFFFF00, stride=0x200, three lines -> line_addr wraps to 0x00000100 on the second line.
REQ-050 mem_ack held low for 20 cycles -> mem_addr and mem_len stay stable; vs during DATA -> burst completes, then the frame restarts at base.
REQ-051 fifo_rd on an empty FIFO three times, with the macro defined -> underrun=1, underrun_cnt=3; with the macro undefined -> both 0.
REQ-052 Reset asserted mid-DATA -> all outputs at reset values in the same cycle; later mem_valid words are not pushed.
